alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single-cycle integer ALU (ops: 0000 add, 0001 sub, 0010 and, 0011 or, all other codes give result 0) between NREQ requesters, e.g. the execute stage, the address-generation path and a debug port.
- Round-robin arbitration with a valid/ready request handshake per requester.
- Drives the ALU operand and control ports combinationally from the granted requester.
- Captures result and zero flag in a single response register tagged with the requester id, held until the consumer accepts it.

Parameters:
- WIDTH, 32, operand and result width.
- NREQ, 2, number of requesters; legal range 2..8.
- IDW, $clog2(NREQ), localparam, requester-id width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept.
- req_a  in  NREQ*WIDTH  packed operand A; requester i at slice [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  packed operand B.
- req_ctrl  in  NREQ*4  packed ALU control codes.
- alu_a  out  WIDTH  operand A to the ALU.
- alu_b  out  WIDTH  operand B to the ALU.
- alu_ctrl  out  4  control code to the ALU.
- alu_result  in  WIDTH  ALU result.
- alu_zero  in  1  ALU zero flag.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accept.
- rsp_data  out  WIDTH  registered result.
- rsp_zero  out  1  registered zero flag.
- rsp_err  out  1  ctrl code was not 0000..0011.
- rsp_id  out  IDW  index of the requester that produced the response.

Behaviour:
- Reset (async, rst_n=0):
  - rsp_valid=0; rsp_data, rsp_zero, rsp_err and rsp_id all 0.
  - Round-robin pointer last=NREQ-1, so requester 0 wins first.
  - req_ready=0 while in reset.
- Asserting reset mid-operation discards any pending response with no handshake.
- Grant, combinational each cycle:
  - Search req_valid starting at index last+1, wrapping modulo NREQ; the first set bit wins.
  - grant is one-hot, or zero if no requester is valid.
  - grant may change between cycles while the response register is blocked.
- Requester protocol: once req_valid is high, the requester holds it and its operands stable until req_ready.
- ALU drive: alu_a, alu_b and alu_ctrl come from the granted requester's slices; all zeros when there is no grant.
- Handshake:
  - can_accept = ~rsp_valid | rsp_ready.
  - req_ready[i] = grant[i] & can_accept.
  - At most one req_ready bit is set per cycle.
- Accept on the clock edge when any req_valid & req_ready:
  - rsp_data <= alu_result; rsp_zero <= alu_zero.
  - rsp_err <= (ctrl > 4'b0011); rsp_id <= granted index.
  - rsp_valid <= 1; last <= granted index.
- Latency: one cycle from accept to rsp_valid.
- Throughput: one operation per cycle while rsp_ready=1, because a drain and a new accept may occur in the same cycle (back-to-back).
- Drain without a new accept: rsp_valid <= 0. rsp_data and the other response fields hold their last value.
- Backpressure:
  - While rsp_valid=1 and rsp_ready=0, the response fields are stable, req_ready is all 0 and last is unchanged.
- Illegal ctrl codes are still executed: the ALU gives 0, so rsp_zero=1 and rsp_err=1.
- Arithmetic wraps modulo 2^WIDTH; the arbiter adds no flags beyond zero and err.
- State is encoded as IDLE (rsp_valid=0) and HOLD (rsp_valid=1):
  - IDLE→HOLD on accept.
  - HOLD→HOLD on drain plus accept, or on stall.
  - HOLD→IDLE on drain with no accept.

Decomposition:
- Shared package alu_pkg:
  - ALU_ADD=4'b0000, ALU_SUB=4'b0001, ALU_AND=4'b0010, ALU_OR=4'b0011.
  - ALU_CTRL_W=4.
  - Function is_legal_ctrl.
- One sub-module, rr_arbiter: inputs req[NREQ], last[IDW]; outputs grant one-hot and grant_idx.
- The ALU itself stays external, wired through the alu_* ports.

Test Plan:
- Single request: req0 a=5, b=3, ctrl=0000, rsp_ready=1 → next cycle rsp_valid=1, rsp_data=8, rsp_zero=0, rsp_err=0, rsp_id=0.
- Contention: both requesters valid for 4 cycles, req0 sub 7−7, req1 or 0xF0|0x0F → accept order 0,1,0,1; req0 responses data=0 zero=1; req1 responses data=0xFF; rsp_valid held high.
- Backpressure: rsp_ready=0 for 3 cycles after the first accept → req_ready=0, rsp_data stable; the first cycle with rsp_ready=1 drains and accepts the pending request in the same edge.
- Illegal op: ctrl=0111, a=9, b=9 → rsp_data=0, rsp_zero=1, rsp_err=1.
- Wrap: add 0xFFFFFFFF+1 → rsp_data=0, rsp_zero=1; sub 0−1 → 0xFFFFFFFF.
- Reset while HOLD with rsp_ready=0: rst_n=0 → rsp_valid=0 immediately (async); after release with both requesters valid, requester 0 is granted first.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: control encodings, response state and
// the legal-opcode predicate.
package alu_pkg;

  localparam int ALU_CTRL_W = 4;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0011;

  // IDLE: response register empty; HOLD: response waiting for the consumer.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } rsp_state_e;

  function automatic logic is_legal_ctrl(input logic [ALU_CTRL_W-1:0] ctrl);
    return ctrl <= ALU_OR;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans req starting one past last, wrapping
// modulo NREQ, and returns a one-hot grant plus its index.
module rr_arbiter #(
  parameter  int NREQ = 2,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic found;
  int   idx;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external single-cycle ALU between NREQ requesters with round-robin
// arbitration and a single registered, id-tagged response slot.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int NREQ  = 2,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*WIDTH-1:0]      req_a,
  input  logic [NREQ*WIDTH-1:0]      req_b,
  input  logic [NREQ*ALU_CTRL_W-1:0] req_ctrl,
  output logic [WIDTH-1:0]           alu_a,
  output logic [WIDTH-1:0]           alu_b,
  output logic [ALU_CTRL_W-1:0]      alu_ctrl,
  input  logic [WIDTH-1:0]           alu_result,
  input  logic                       alu_zero,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WIDTH-1:0]           rsp_data,
  output logic                       rsp_zero,
  output logic                       rsp_err,
  output logic [IDW-1:0]             rsp_id
);

  rsp_state_e      state_q, state_d;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic [IDW-1:0]  last_q;
  logic            can_accept;
  logic            accept;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req       (req_valid),
    .last      (last_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Grant is one-hot, so OR-ing the selected slices yields a plain mux.
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        alu_a    = alu_a    | req_a[i*WIDTH +: WIDTH];
        alu_b    = alu_b    | req_b[i*WIDTH +: WIDTH];
        alu_ctrl = alu_ctrl | req_ctrl[i*ALU_CTRL_W +: ALU_CTRL_W];
      end
    end
  end

  assign rsp_valid  = (state_q == HOLD);
  assign can_accept = ~rsp_valid | rsp_ready;
  // Gated by rst_n so no requester sees a handshake while reset is held.
  assign req_ready  = rst_n ? (grant & {NREQ{can_accept}}) : '0;
  assign accept     = |(req_valid & req_ready);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = HOLD;
      HOLD: if (rsp_ready && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: the response fields are reset too, because their reset value is
  // architecturally visible; last starts at NREQ-1 so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
      rsp_zero <= 1'b0;
      rsp_err  <= 1'b0;
      rsp_id   <= '0;
      last_q   <= IDW'(NREQ - 1);
    end else if (accept) begin
      rsp_data <= alu_result;
      rsp_zero <= alu_zero;
      rsp_err  <= ~is_legal_ctrl(alu_ctrl);
      rsp_id   <= grant_idx;
      last_q   <= grant_idx;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with two requesters and a
// behavioural ALU attached to the alu_* ports.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int WIDTH = 32;
  localparam int NREQ  = 2;
  localparam int IDW   = $clog2(NREQ);

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic [NREQ-1:0]            req_valid = '0;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ*WIDTH-1:0]      req_a = '0;
  logic [NREQ*WIDTH-1:0]      req_b = '0;
  logic [NREQ*ALU_CTRL_W-1:0] req_ctrl = '0;
  logic [WIDTH-1:0]           alu_a, alu_b;
  logic [ALU_CTRL_W-1:0]      alu_ctrl;
  logic [WIDTH-1:0]           alu_result;
  logic                       alu_zero;
  logic                       rsp_valid;
  logic                       rsp_ready = 1'b0;
  logic [WIDTH-1:0]           rsp_data;
  logic                       rsp_zero, rsp_err;
  logic [IDW-1:0]             rsp_id;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ctrl   (req_ctrl),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err),
    .rsp_id     (rsp_id)
  );

  // External ALU behaviour.
  always_comb begin
    case (alu_ctrl)
      ALU_ADD: alu_result = alu_a + alu_b;
      ALU_SUB: alu_result = alu_a - alu_b;
      ALU_AND: alu_result = alu_a & alu_b;
      ALU_OR:  alu_result = alu_a | alu_b;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic set_req(input int i, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [3:0] ctrl);
    req_a[i*WIDTH +: WIDTH]  = a;
    req_b[i*WIDTH +: WIDTH]  = b;
    req_ctrl[i*4 +: 4]       = ctrl;
    req_valid[i]             = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_req(0, 32'd1, 32'd1, ALU_ADD);
    set_req(1, 32'd2, 32'd2, ALU_ADD);
    rsp_ready = 1'b1;
    step();
    step();
    n_total++;
    if (req_ready !== 2'b00) $display("FAIL reset_req_ready: got %b want 00", req_ready);
    else n_pass++;
    n_total++;
    if ({rsp_valid, rsp_data, rsp_zero, rsp_err, rsp_id} !== '0)
      $display("FAIL reset_rsp: valid=%b data=%h zero=%b err=%b id=%0d want all 0",
               rsp_valid, rsp_data, rsp_zero, rsp_err, rsp_id);
    else n_pass++;
    req_valid = '0;
    rst_n = 1'b1;
    step();
  endtask

  // Fresh after reset: order must be 0,1,0,1 with back-to-back responses.
  task automatic test_contention();
    logic [IDW-1:0]   exp_id;
    logic [WIDTH-1:0] exp_data;
    set_req(0, 32'd7, 32'd7, ALU_SUB);
    set_req(1, 32'hF0, 32'h0F, ALU_OR);
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_id   = IDW'(k % 2);
      exp_data = (k % 2 == 0) ? 32'h0 : 32'hFF;
      #1;
      n_total++;
      if (req_ready !== (2'b01 << exp_id))
        $display("FAIL contention_ready[%0d]: got %b want %b", k, req_ready, 2'b01 << exp_id);
      else n_pass++;
      step();
      n_total++;
      if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_data !== exp_data ||
          rsp_zero !== (k % 2 == 0) || rsp_err !== 1'b0)
        $display("FAIL contention_rsp[%0d]: valid=%b id=%0d data=%h zero=%b err=%b want 1 %0d %h %b 0",
                 k, rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err, exp_id, exp_data, (k % 2 == 0));
      else n_pass++;
    end
    req_valid = '0;
    step();
    n_total++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'hFF)
      $display("FAIL drain_hold: valid=%b data=%h want 0 000000ff", rsp_valid, rsp_data);
    else n_pass++;
  endtask

  task automatic test_single();
    set_req(0, 32'd5, 32'd3, ALU_ADD);
    rsp_ready = 1'b1;
    #1;
    n_total++;
    if (req_ready !== 2'b01) $display("FAIL single_ready: got %b want 01", req_ready);
    else n_pass++;
    step();
    req_valid = '0;
    n_total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'd8 || rsp_zero !== 1'b0 ||
        rsp_err !== 1'b0 || rsp_id !== 0)
      $display("FAIL single_rsp: valid=%b data=%h zero=%b err=%b id=%0d want 1 8 0 0 0",
               rsp_valid, rsp_data, rsp_zero, rsp_err, rsp_id);
    else n_pass++;
    step();
  endtask

  task automatic test_backpressure();
    set_req(0, 32'd1, 32'd2, ALU_ADD);
    rsp_ready = 1'b1;
    step();
    set_req(0, 32'd10, 32'd20, ALU_ADD);
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_total++;
      if (req_ready !== 2'b00) $display("FAIL bp_ready[%0d]: got %b want 00", k, req_ready);
      else n_pass++;
      step();
      n_total++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'd3 || rsp_id !== 0)
        $display("FAIL bp_hold[%0d]: valid=%b data=%h id=%0d want 1 3 0", k, rsp_valid, rsp_data, rsp_id);
      else n_pass++;
    end
    rsp_ready = 1'b1;
    #1;
    n_total++;
    if (req_ready !== 2'b01) $display("FAIL bp_release_ready: got %b want 01", req_ready);
    else n_pass++;
    step();
    req_valid = '0;
    n_total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'd30)
      $display("FAIL bp_release_rsp: valid=%b data=%h want 1 1e", rsp_valid, rsp_data);
    else n_pass++;
    step();
  endtask

  task automatic test_illegal();
    set_req(1, 32'd9, 32'd9, 4'b0111);
    rsp_ready = 1'b1;
    step();
    req_valid = '0;
    n_total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'd0 || rsp_zero !== 1'b1 ||
        rsp_err !== 1'b1 || rsp_id !== 1)
      $display("FAIL illegal_rsp: valid=%b data=%h zero=%b err=%b id=%0d want 1 0 1 1 1",
               rsp_valid, rsp_data, rsp_zero, rsp_err, rsp_id);
    else n_pass++;
    step();
  endtask

  task automatic test_wrap();
    set_req(0, 32'hFFFF_FFFF, 32'd1, ALU_ADD);
    rsp_ready = 1'b1;
    step();
    set_req(0, 32'd0, 32'd1, ALU_SUB);
    n_total++;
    if (rsp_data !== 32'd0 || rsp_zero !== 1'b1 || rsp_err !== 1'b0)
      $display("FAIL wrap_add: data=%h zero=%b err=%b want 0 1 0", rsp_data, rsp_zero, rsp_err);
    else n_pass++;
    step();
    req_valid = '0;
    n_total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'hFFFF_FFFF || rsp_zero !== 1'b0)
      $display("FAIL wrap_sub: valid=%b data=%h zero=%b want 1 ffffffff 0", rsp_valid, rsp_data, rsp_zero);
    else n_pass++;
    step();
  endtask

  task automatic test_reset_hold();
    set_req(1, 32'd4, 32'd4, ALU_ADD);
    rsp_ready = 1'b1;
    step();
    req_valid = '0;
    rsp_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'd0 || rsp_id !== 0)
      $display("FAIL async_reset: valid=%b data=%h id=%0d want 0 0 0", rsp_valid, rsp_data, rsp_id);
    else n_pass++;
    set_req(0, 32'd6, 32'd1, ALU_SUB);
    set_req(1, 32'd6, 32'd3, ALU_AND);
    rsp_ready = 1'b1;
    step();
    rst_n = 1'b1;
    #1;
    n_total++;
    if (req_ready !== 2'b01) $display("FAIL post_reset_ready: got %b want 01", req_ready);
    else n_pass++;
    step();
    n_total++;
    if (rsp_id !== 0 || rsp_data !== 32'd5)
      $display("FAIL post_reset_first: id=%0d data=%h want 0 5", rsp_id, rsp_data);
    else n_pass++;
    step();
    req_valid = '0;
    n_total++;
    if (rsp_id !== 1 || rsp_data !== 32'd2)
      $display("FAIL post_reset_second: id=%0d data=%h want 1 2", rsp_id, rsp_data);
    else n_pass++;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_backpressure();
    test_illegal();
    test_wrap();
    test_reset_hold();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
